regfile_writeback: RTL

Write-side initiator for the 64-bit, 32-entry `Register_File` in the RISC-V pipeline. It merges single-cycle ALU results and multi-cycle load results into the register file's single write port. Load results pass through a small FIFO, and ALU results take priority. It drives `addressw`/`writeData`/`writeEn` from registers. An optional scoreboard tracks destinations of in-flight loads for hazard detection.

---
 rtl/regfile_writeback.sv | 128 ++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Write-port arbiter for the register file: ALU results win, loads wait in a small FIFO.
// Define WB_SCOREBOARD_EN to add the in-flight load scoreboard (issue_valid/issue_rd/busy_mask).
module regfile_writeback #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_rd,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_rd,
  input  logic [DATA_W-1:0]          mem_data,
  output logic [ADDR_W-1:0]          addressw,
  output logic [DATA_W-1:0]          writeData,
  output logic                       writeEn,
`ifdef WB_SCOREBOARD_EN
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_rd,
  output logic [31:0]                busy_mask,
`endif
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              kill;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];
  entry_t            head;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              push, pop, alu_kill;

  assign mem_ready  = count_q < CW'(DEPTH);
  assign fifo_count = count_q;
  assign addressw   = addr_q;
  assign writeData  = data_q;
  assign writeEn    = we_q;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    head     = fifo_q[rd_ptr_q];
    push     = mem_valid && mem_ready;
    pop      = !alu_valid && (count_q != '0);
    alu_kill = alu_valid && (alu_rd != '0);

    // A younger ALU write to the same rd makes any buffered load result stale.
    for (int i = 0; i < DEPTH; i++)
      if (alu_kill && fifo_q[i].rd == alu_rd) fifo_d[i].kill = 1'b1;

    if (push) begin
      fifo_d[wr_ptr_q] = '{rd: mem_rd, data: mem_data, kill: alu_kill && (mem_rd == alu_rd)};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (alu_valid) begin
      addr_d = alu_rd;
      data_d = alu_data;
      we_d   = alu_rd != '0;
    end else if (pop) begin
      addr_d = head.rd;
      data_d = head.data;
      we_d   = (head.rd != '0) && !head.kill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  assign busy_mask = busy_q;

  // Clear on pop first so a same-edge issue to that register re-sets it.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < 32; i++) begin
      if (pop && head.rd == ADDR_W'(i)) busy_d[i] = 1'b0;
      if (issue_valid && issue_rd == ADDR_W'(i)) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
`endif

endmodule
